// File: rtl/hazard_if.sv
// Hazard-unit signal bundle between the ID/EX/MEM stage registers and the hazard unit.
// Statistics signals exist only when HAZARD_STATS_EN is defined.
`default_nettype none

interface hazard_if #(
  parameter int ADDR_BITS = 5
`ifdef HAZARD_STATS_EN
  , parameter int STALL_CNT_BITS = 16
`endif
);
  logic [ADDR_BITS-1:0] id_rs;
  logic [ADDR_BITS-1:0] id_rt;
  logic                 id_uses_rs;
  logic                 id_uses_rt;
  logic                 id_is_branch;
  logic [ADDR_BITS-1:0] ex_rd;
  logic                 ex_reg_write;
  logic                 ex_mem_to_reg;
  logic [ADDR_BITS-1:0] mem_rd;
  logic                 mem_reg_write;
  logic                 mem_mem_to_reg;
  logic                 mc_start;
  logic                 mc_kill;
  logic                 hold_front;
  logic                 bubble_id_ex;
  logic                 hold_ex;
  logic                 bubble_ex_mem;
  logic                 mc_done;
  logic [1:0]           stall_cause;
`ifdef HAZARD_STATS_EN
  logic                      stats_clear;
  logic [STALL_CNT_BITS-1:0] cnt_load_use;
  logic [STALL_CNT_BITS-1:0] cnt_branch;
  logic [STALL_CNT_BITS-1:0] cnt_mc;
`endif

  modport master (
`ifdef HAZARD_STATS_EN
    output stats_clear,
    input  cnt_load_use, cnt_branch, cnt_mc,
`endif
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
    output ex_rd, ex_reg_write, ex_mem_to_reg,
    output mem_rd, mem_reg_write, mem_mem_to_reg,
    output mc_start, mc_kill,
    input  hold_front, bubble_id_ex, hold_ex, bubble_ex_mem, mc_done, stall_cause
  );

  modport slave (
`ifdef HAZARD_STATS_EN
    input  stats_clear,
    output cnt_load_use, cnt_branch, cnt_mc,
`endif
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
    input  ex_rd, ex_reg_write, ex_mem_to_reg,
    input  mem_rd, mem_reg_write, mem_mem_to_reg,
    input  mc_start, mc_kill,
    output hold_front, bubble_id_ex, hold_ex, bubble_ex_mem, mc_done, stall_cause
  );
endinterface

`default_nettype wire

// File: rtl/hazard_unit.sv
// Load-use / branch-in-ID hazard detector and multi-cycle EX sequencer for the 5-stage MIPS core.
// Optional stall statistics counters enabled by defining HAZARD_STATS_EN.
`default_nettype none

module hazard_unit #(
  parameter int ADDR_BITS  = 5,
  parameter int MC_LATENCY = 4
`ifdef HAZARD_STATS_EN
  , parameter int STALL_CNT_BITS = 16
`endif
) (
  input  wire logic clk,
  input  wire logic reset,
  hazard_if.slave   hz
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MC_WAIT = 1'b1;
  localparam logic [7:0] CNT_LOAD = 8'(MC_LATENCY - 1);

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_LU   = 2'd1;
  localparam logic [1:0] CAUSE_BR   = 2'd2;
  localparam logic [1:0] CAUSE_MC   = 2'd3;

  logic [0:0] state;
  logic [7:0] cnt;
  logic [1:0] cause_q;

  logic ex_hit, mem_hit, load_use, branch_hz, mc_hold, mc_last, hazard;
  logic [1:0] cause_d;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic src_hit(input logic [ADDR_BITS-1:0] dst, input logic we);
    return we && (dst != '0) &&
           ((hz.id_uses_rs && (hz.id_rs == dst)) || (hz.id_uses_rt && (hz.id_rt == dst)));
  endfunction

  always_comb begin
    ex_hit    = src_hit(hz.ex_rd, hz.ex_reg_write);
    mem_hit   = src_hit(hz.mem_rd, hz.mem_reg_write);
    load_use  = hz.ex_mem_to_reg && ex_hit;
    branch_hz = hz.id_is_branch &&
                ((!hz.ex_mem_to_reg && ex_hit) || (hz.mem_mem_to_reg && mem_hit));
    mc_hold   = !hz.mc_kill && (((state == IDLE) && hz.mc_start) ||
                                ((state == MC_WAIT) && (cnt != 8'd0)));
    mc_last   = !hz.mc_kill && (state == MC_WAIT) && (cnt == 8'd0);
    hazard    = !hz.mc_kill && !mc_hold && (load_use || branch_hz);

    cause_d = CAUSE_NONE;
    if (mc_hold)
      cause_d = CAUSE_MC;
    else if (hazard && load_use)
      cause_d = CAUSE_LU;
    else if (hazard)
      cause_d = CAUSE_BR;
  end

  assign hz.hold_front    = mc_hold || hazard;
  assign hz.bubble_id_ex  = hazard;
  assign hz.hold_ex       = mc_hold;
  assign hz.bubble_ex_mem = mc_hold;
  assign hz.mc_done       = mc_last;
  assign hz.stall_cause   = cause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      cause_q <= CAUSE_NONE;
    end else begin
      cause_q <= cause_d;
      if (hz.mc_kill) begin
        state <= IDLE;
        cnt   <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (hz.mc_start) begin
              state <= MC_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
          MC_WAIT: begin
            if (cnt != 8'd0)
              cnt <= cnt - 8'd1;
            else
              state <= IDLE;
          end
          default: begin
            state <= IDLE;
            cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_BITS-1:0] cnt_lu_q, cnt_br_q, cnt_mc_q;

  always_ff @(posedge clk) begin
    if (reset || hz.stats_clear) begin
      cnt_lu_q <= '0;
      cnt_br_q <= '0;
      cnt_mc_q <= '0;
    end else begin
      if ((cause_d == CAUSE_LU) && (cnt_lu_q != '1)) cnt_lu_q <= cnt_lu_q + 1'b1;
      if ((cause_d == CAUSE_BR) && (cnt_br_q != '1)) cnt_br_q <= cnt_br_q + 1'b1;
      if ((cause_d == CAUSE_MC) && (cnt_mc_q != '1)) cnt_mc_q <= cnt_mc_q + 1'b1;
    end
  end

  assign hz.cnt_load_use = cnt_lu_q;
  assign hz.cnt_branch   = cnt_br_q;
  assign hz.cnt_mc       = cnt_mc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed literal checks plus randomized traffic against a cycle-level model.
`default_nettype none

module tb_hazard_unit;
  localparam int AB  = 5;
  localparam int LAT = 4;
`ifdef HAZARD_STATS_EN
  localparam int SB  = 2;
  localparam int SAT = (1 << SB) - 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
  hazard_if #(.ADDR_BITS(AB), .STALL_CNT_BITS(SB)) hif ();
  hazard_unit #(.ADDR_BITS(AB), .MC_LATENCY(LAT), .STALL_CNT_BITS(SB)) dut (
    .clk(clk), .reset(reset), .hz(hif));
`else
  hazard_if #(.ADDR_BITS(AB)) hif ();
  hazard_unit #(.ADDR_BITS(AB), .MC_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .hz(hif));
`endif

  int errors = 0;
  int checks = 0;

  // Model state: cycles elapsed since a multi-cycle start (0 = no op in flight).
  int busy = 0, busy_n = 0;
  int exp_cause = 0, cause_n = 0;
  int m_lu = 0, m_br = 0, m_mc = 0;
  int m_lu_n = 0, m_br_n = 0, m_mc_n = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit used_hit(input logic [AB-1:0] dst, input logic we);
    return we && (dst != 0) &&
           ((hif.id_uses_rs && hif.id_rs == dst) || (hif.id_uses_rt && hif.id_rt == dst));
  endfunction

  task automatic clear_inputs();
    hif.id_rs = 0; hif.id_rt = 0; hif.id_uses_rs = 0; hif.id_uses_rt = 0;
    hif.id_is_branch = 0; hif.ex_rd = 0; hif.ex_reg_write = 0; hif.ex_mem_to_reg = 0;
    hif.mem_rd = 0; hif.mem_reg_write = 0; hif.mem_mem_to_reg = 0;
    hif.mc_start = 0; hif.mc_kill = 0;
`ifdef HAZARD_STATS_EN
    hif.stats_clear = 0;
`endif
  endtask

  function automatic int sat_inc(input int v);
`ifdef HAZARD_STATS_EN
    return (v >= SAT) ? v : v + 1;
`else
    return v + 1;
`endif
  endfunction

  // Mid-cycle: compare every output with the model and prepare its next state.
  task automatic settle();
    bit k, lu, br, holding, done, haz;
    #4;
    k  = hif.mc_kill;
    lu = hif.ex_mem_to_reg && used_hit(hif.ex_rd, hif.ex_reg_write);
    br = hif.id_is_branch && ((!hif.ex_mem_to_reg && used_hit(hif.ex_rd, hif.ex_reg_write)) ||
                              (hif.mem_mem_to_reg && used_hit(hif.mem_rd, hif.mem_reg_write)));
    holding = !k && ((busy == 0 && hif.mc_start) || (busy >= 1 && busy < LAT));
    done    = !k && (busy == LAT);
    haz     = !k && !holding && (lu || br);

    chk("hold_front",    hif.hold_front,    int'(holding || haz));
    chk("bubble_id_ex",  hif.bubble_id_ex,  int'(haz));
    chk("hold_ex",       hif.hold_ex,       int'(holding));
    chk("bubble_ex_mem", hif.bubble_ex_mem, int'(holding));
    chk("mc_done",       hif.mc_done,       int'(done));
    chk("stall_cause",   hif.stall_cause,   exp_cause);

    busy_n  = (reset || k || !holding) ? 0 : busy + 1;
    cause_n = (reset || k) ? 0 : holding ? 3 : (haz && lu) ? 1 : haz ? 2 : 0;

    m_lu_n = m_lu; m_br_n = m_br; m_mc_n = m_mc;
`ifdef HAZARD_STATS_EN
    chk("cnt_load_use", hif.cnt_load_use, m_lu);
    chk("cnt_branch",   hif.cnt_branch,   m_br);
    chk("cnt_mc",       hif.cnt_mc,       m_mc);
    if (reset || hif.stats_clear) begin
      m_lu_n = 0; m_br_n = 0; m_mc_n = 0;
    end else begin
      if (cause_n == 1) m_lu_n = sat_inc(m_lu);
      if (cause_n == 2) m_br_n = sat_inc(m_br);
      if (cause_n == 3) m_mc_n = sat_inc(m_mc);
    end
`endif
  endtask

  task automatic adv();
    @(posedge clk);
    busy = busy_n; exp_cause = cause_n;
    m_lu = m_lu_n; m_br = m_br_n; m_mc = m_mc_n;
    #1;
  endtask

  task automatic set_load_ex(input int rd);
    hif.ex_rd = AB'(rd); hif.ex_reg_write = 1; hif.ex_mem_to_reg = 1;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    settle(); adv();
    settle(); adv();
    reset = 0;
    settle();
    chk("reset_stall_cause", hif.stall_cause, 0);
    chk("reset_hold_front", hif.hold_front, 0);
    adv();

    // Load-use on rs
    set_load_ex(8); hif.id_rs = 8; hif.id_uses_rs = 1;
    settle();
    chk("lu_hold_front", hif.hold_front, 1);
    chk("lu_bubble", hif.bubble_id_ex, 1);
    chk("lu_hold_ex", hif.hold_ex, 0);
    adv();
    clear_inputs();
    settle();
    chk("lu_cause", hif.stall_cause, 1);
    adv();
    // Register 0 never hazards
    set_load_ex(0); hif.id_rs = 0; hif.id_uses_rs = 1;
    settle();
    chk("r0_no_stall", hif.hold_front, 0);
    adv();
    // Unused rt operand
    clear_inputs(); set_load_ex(8); hif.id_rt = 8;
    settle();
    chk("unused_rt", hif.hold_front, 0);
    adv();

    // Branch behind load: two stall cycles
    clear_inputs(); set_load_ex(9); hif.id_is_branch = 1; hif.id_rs = 9; hif.id_uses_rs = 1;
    settle();
    chk("brld_c1", hif.hold_front, 1);
    adv();
    hif.ex_rd = 0; hif.ex_reg_write = 0; hif.ex_mem_to_reg = 0;
    hif.mem_rd = 9; hif.mem_reg_write = 1; hif.mem_mem_to_reg = 1;
    settle();
    chk("brld_c2", hif.hold_front, 1);
    chk("brld_c2_cause", hif.stall_cause, 1);
    adv();
    hif.mem_rd = 0; hif.mem_reg_write = 0; hif.mem_mem_to_reg = 0;
    settle();
    chk("brld_c3", hif.hold_front, 0);
    chk("brld_c3_cause", hif.stall_cause, 2);
    adv();
    // Branch behind ALU op: one stall cycle
    hif.ex_rd = 9; hif.ex_reg_write = 1;
    settle();
    chk("bralu_c1", hif.hold_front, 1);
    adv();
    hif.ex_rd = 0; hif.ex_reg_write = 0; hif.mem_rd = 9; hif.mem_reg_write = 1;
    settle();
    chk("bralu_c2", hif.hold_front, 0);
    chk("bralu_cause", hif.stall_cause, 2);
    adv();

    // Multi-cycle op with a concurrent load-use masked during the hold
    clear_inputs(); set_load_ex(8); hif.id_rs = 8; hif.id_uses_rs = 1; hif.mc_start = 1;
    for (int c = 1; c <= LAT; c++) begin
      settle();
      chk("mc_hold_ex", hif.hold_ex, 1);
      chk("mc_masked", hif.bubble_id_ex, 0);
      chk("mc_done_early", hif.mc_done, 0);
      adv();
      hif.mc_start = 0;
    end
    settle();
    chk("mc_done_c5", hif.mc_done, 1);
    chk("mc_release", hif.hold_ex, 0);
    chk("mc_lu_after", hif.bubble_id_ex, 1);
    adv();
    clear_inputs();
    settle();
    chk("mc_done_once", hif.mc_done, 0);
    chk("mc_cause_lu", hif.stall_cause, 1);
    adv();

    // Kill on the second hold cycle
    hif.mc_start = 1;
    settle(); adv();
    hif.mc_start = 0; hif.mc_kill = 1;
    settle();
    chk("kill_hold_front", hif.hold_front, 0);
    chk("kill_hold_ex", hif.hold_ex, 0);
    adv();
    hif.mc_kill = 0;
    for (int c = 0; c < LAT + 1; c++) begin
      settle();
      chk("kill_no_done", hif.mc_done, 0);
      chk("kill_idle", hif.hold_ex, 0);
      adv();
    end

    // Reset during MC_WAIT
    hif.mc_start = 1;
    settle(); adv();
    hif.mc_start = 0;
    settle(); adv();
    reset = 1;
    settle(); adv();
    reset = 0;
    settle();
    chk("rst_mid_hold_ex", hif.hold_ex, 0);
    chk("rst_mid_cause", hif.stall_cause, 0);
    adv();
    for (int c = 0; c < LAT; c++) begin settle(); adv(); end

`ifdef HAZARD_STATS_EN
    hif.stats_clear = 1;
    settle(); adv();
    hif.stats_clear = 0;
    set_load_ex(8); hif.id_rs = 8; hif.id_uses_rs = 1;
    for (int c = 0; c < 5; c++) begin settle(); adv(); end
    clear_inputs();
    settle();
    chk("stats_sat", hif.cnt_load_use, 3);
    adv();
    hif.stats_clear = 1; set_load_ex(8); hif.id_rs = 8; hif.id_uses_rs = 1;
    settle(); adv();
    clear_inputs();
    settle();
    chk("stats_clear", hif.cnt_load_use, 0);
    adv();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      hif.id_rs          = AB'($urandom_range(0, 3));
      hif.id_rt          = AB'($urandom_range(0, 3));
      hif.id_uses_rs     = 1'($urandom_range(0, 1));
      hif.id_uses_rt     = 1'($urandom_range(0, 1));
      hif.id_is_branch   = ($urandom_range(0, 3) == 0);
      hif.ex_rd          = AB'($urandom_range(0, 3));
      hif.ex_reg_write   = 1'($urandom_range(0, 1));
      hif.ex_mem_to_reg  = 1'($urandom_range(0, 1));
      hif.mem_rd         = AB'($urandom_range(0, 3));
      hif.mem_reg_write  = 1'($urandom_range(0, 1));
      hif.mem_mem_to_reg = 1'($urandom_range(0, 1));
      hif.mc_start       = ($urandom_range(0, 7) == 0);
      hif.mc_kill        = ($urandom_range(0, 19) == 0);
      reset              = ($urandom_range(0, 59) == 0);
`ifdef HAZARD_STATS_EN
      hif.stats_clear    = ($urandom_range(0, 39) == 0);
`endif
      settle();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
